// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, one-cycle
// data_valid / frame_err pulses and a BREAK hold state for a line held low.
module uart_rx #(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int BAUD_WIDTH  = int'(CLOCK_SPEED / BAUD_RATE),
    parameter int HALF_WIDTH  = BAUD_WIDTH / 2,
    parameter bit INVERT_DATA = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [8:0] BAUD_LAST = 9'(BAUD_WIDTH - 1);
    localparam logic [8:0] HALF_LAST = 9'(HALF_WIDTH - 1);
    localparam logic [7:0] DATA_MASK = {8{INVERT_DATA}};

    state_t     state_q;
    logic [8:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       sync1_q;
    logic       sync2_q;
    logic       rx_s;

    assign rx_s = sync2_q;
    assign busy = (state_q != ST_IDLE);

    // Synchronizer, bit timing, shift register and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 9'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            data       <= 8'd0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 9'd0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= 9'd0;
                        bit_idx_q <= 3'd0;
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BAUD_LAST) begin
                        cnt_q     <= 9'd0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a start bit right after the stop bit be seen.
                    if (cnt_q == BAUD_LAST) begin
                        cnt_q <= 9'd0;
                        if (rx_s) begin
                            data       <= shift_q ^ DATA_MASK;
                            data_valid <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                ST_BREAK: begin
                    cnt_q <= 9'd0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 9'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; the line is driven with inverted payload bits,
// as the upstream transmitter does, at a reduced clock so each bit is 20 clocks.
module tb_uart_rx;

    localparam int BW = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         vcount = 0;
    int         fcount = 0;
    int         both_cnt = 0;
    logic [7:0] vdata [64];
    int         vtime [64];
    logic       vbusy [64];
    bit         busy_seen = 1'b0;

    uart_rx #(
        .BAUD_RATE  (115_200),
        .CLOCK_SPEED(2_304_000),
        .INVERT_DATA(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid) begin
            if (vcount < 64) begin
                vdata[vcount] = data;
                vtime[vcount] = cyc;
                vbusy[vcount] = busy;
            end
            vcount++;
        end
        if (frame_err) fcount++;
        if (data_valid && frame_err) both_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] line, input logic stop_v, input int stop_len);
        fall_cyc = cyc;
        rx = 1'b0;
        wait_cyc(BW);
        for (int i = 0; i < 8; i++) begin
            rx = line[i];
            wait_cyc(BW);
        end
        rx = stop_v;
        wait_cyc(stop_len);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(~b, 1'b1, BW);
    endtask

    int v0;
    int f0;
    int d;
    logic [7:0] b2b [3];
    logic [7:0] lb [4];

    initial begin
        b2b = '{8'h00, 8'hFF, 8'h81};
        lb  = '{8'h00, 8'h55, 8'hAA, 8'hFF};

        @(negedge clk);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        wait_cyc(5);

        // Single frame: line 0x5A decodes to 0xA5
        v0 = vcount; f0 = fcount;
        send_frame(8'h5A, 1'b1, BW);
        wait_cyc(5);
        chk("single_cnt", vcount - v0, 32'd1);
        chk("single_data", {24'd0, vdata[v0]}, 32'hA5);
        chk("single_ferr", fcount - f0, 32'd0);
        chk("single_busy", {31'd0, vbusy[v0]}, 32'd0);
        d = vtime[v0] - fall_cyc;
        chk("single_latency", {31'd0, (d >= 191 && d <= 195)}, 32'd1);

        // Glitch shorter than half a bit
        v0 = vcount; f0 = fcount;
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(3 * BW);
        chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("glitch_busy_end", {31'd0, busy}, 32'd0);
        chk("glitch_valid", vcount - v0, 32'd0);
        chk("glitch_ferr", fcount - f0, 32'd0);
        chk("glitch_data", {24'd0, data}, 32'hA5);

        // Framing error with stop held low, then a good frame
        v0 = vcount; f0 = fcount;
        send_frame(8'hFF, 1'b0, 3 * BW);
        chk("ferr_busy_break", {31'd0, busy}, 32'd1);
        chk("ferr_cnt", fcount - f0, 32'd1);
        chk("ferr_valid", vcount - v0, 32'd0);
        chk("ferr_data_hold", {24'd0, data}, 32'hA5);
        wait_cyc(5);
        chk("ferr_busy_end", {31'd0, busy}, 32'd0);
        v0 = vcount;
        send_byte(8'h3C);
        wait_cyc(5);
        chk("after_ferr_cnt", vcount - v0, 32'd1);
        chk("after_ferr_data", {24'd0, data}, 32'h3C);

        // Back-to-back frames with no idle gap
        v0 = vcount; f0 = fcount;
        for (int i = 0; i < 3; i++) send_byte(b2b[i]);
        wait_cyc(5);
        chk("b2b_cnt", vcount - v0, 32'd3);
        chk("b2b_ferr", fcount - f0, 32'd0);
        for (int i = 0; i < 3; i++) chk("b2b_data", {24'd0, vdata[v0 + i]}, {24'd0, b2b[i]});
        for (int i = 1; i < 3; i++) begin
            d = vtime[v0 + i] - vtime[v0 + i - 1];
            chk("b2b_spacing", {31'd0, (d >= 10 * BW - 1 && d <= 10 * BW + 1)}, 32'd1);
        end

        // Reset during data bit 4
        v0 = vcount; f0 = fcount;
        rx = 1'b0;
        wait_cyc(BW);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_cyc(BW);
        end
        rx = 1'b1;
        wait_cyc(BW / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_data", {24'd0, data}, 32'h00);
        chk("mrst_valid", {31'd0, data_valid}, 32'd0);
        chk("mrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        wait_cyc(8 * BW);
        chk("mrst_no_valid", vcount - v0, 32'd0);
        chk("mrst_no_ferr", fcount - f0, 32'd0);
        send_byte(8'h12);
        wait_cyc(5);
        chk("mrst_next_cnt", vcount - v0, 32'd1);
        chk("mrst_next_data", {24'd0, data}, 32'h12);

        // Loopback-style frames as produced by the transmitter
        for (int i = 0; i < 4; i++) begin
            v0 = vcount; f0 = fcount;
            send_byte(lb[i]);
            wait_cyc(3);
            chk("loop_cnt", vcount - v0, 32'd1);
            chk("loop_data", {24'd0, data}, {24'd0, lb[i]});
            chk("loop_ferr", fcount - f0, 32'd0);
        end

        chk("never_both", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver directly downstream of the UART transmitter on the same link.
- Consumes the 1-start / 8-data / 1-stop, LSB-first serial line.
- Recovers each byte and presents it as a single-cycle-valid parallel word to the consumer logic.
- Link payload polarity matches the transmitter: payload bits are driven inverted on the line; the receiver re-inverts them when INVERT_DATA=1.

Parameters:
- BAUD_RATE, 115_200, bit rate of the line in bit/s.
- CLOCK_SPEED, 50_000_000, clk frequency in Hz.
- BAUD_WIDTH, int'(CLOCK_SPEED/BAUD_RATE) (434), clk cycles per bit.
- HALF_WIDTH, BAUD_WIDTH/2 (217), clk cycles from start-bit falling edge to start-bit mid-sample.
- INVERT_DATA, 1, when 1, output data = ~(received payload); when 0, output data = received payload.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line; idle high.
- data  output  8  last good received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE; counter=0; bit_idx=0.
  - shift register=0; data=0.
  - data_valid=0; frame_err=0; busy=0.
  - Both synchronizer flops=1.
  - Reset mid-frame abandons the frame with no pulse on any output.
- Input sync:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - All decisions use rx_s only.
  - Fixed 2-cycle input latency.
- State IDLE:
  - When rx_s=0, go to START with counter=0.
- State START:
  - counter increments each cycle.
  - At counter==HALF_WIDTH-1, sample rx_s:
    - rx_s=0: go to DATA, counter=0, bit_idx=0.
    - rx_s=1: glitch; return to IDLE with no output activity.
- State DATA:
  - counter increments each cycle.
  - At counter==BAUD_WIDTH-1 (mid-bit), the shift register shifts right with rx_s entering bit 7; counter=0; bit_idx++.
  - After the 8th sample (bit_idx==7 at the sample), go to STOP.
- State STOP:
  - At counter==BAUD_WIDTH-1, sample rx_s:
    - rx_s=1: data <= shift ^ {8{INVERT_DATA}}; data_valid=1 for exactly that one cycle; go to IDLE.
    - rx_s=0: frame_err=1 for one cycle; data unchanged; go to BREAK.
- State BREAK:
  - Wait until rx_s=1, then go to IDLE.
  - Stays in BREAK for a held-low (break) line of any length.
- Counter widths:
  - counter is 9 bits and never exceeds BAUD_WIDTH-1.
  - bit_idx is 3 bits.
- data_valid timing:
  - Asserts in the middle of the stop bit.
  - Occurs 2 + HALF_WIDTH + 9*BAUD_WIDTH cycles (±1) after the falling edge of rx.
- No overrun detection:
  - The consumer must take data on the data_valid cycle.
  - The next good frame overwrites data.
- Back-to-back frames:
  - A start bit beginning immediately after the stop bit is received correctly.
  - IDLE is re-entered at mid-stop-bit, so the next falling edge is seen.
- data_valid and frame_err are never high in the same cycle.

Test Plan:
- Single frame, INVERT_DATA=1: line carries start, 0x5A LSB-first, stop -> one data_valid pulse, data=0xA5, frame_err=0, busy low within 1 cycle of the pulse.
- Glitch: rx low for 100 cycles, then high -> busy pulses, returns to IDLE, no data_valid, no frame_err, data unchanged.
- Framing error: valid start plus 0xFF payload, stop bit driven low for 3*BAUD_WIDTH -> frame_err pulse at mid-stop, data holds its previous value, busy high until rx returns high. A following good frame for 0x3C (line 0xC3) then gives data=0x3C.
- Back-to-back: three frames 0x00, 0xFF, 0x81 with no idle gap -> exactly three data_valid pulses, 10*BAUD_WIDTH (±1) apart, data in order.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 -> all outputs 0 next cycle, no pulses. The next full frame (0x12) is received as 0x12.
- Loopback with the transmitter (same parameters): send 0x00, 0x55, 0xAA, 0xFF -> received data equals sent data each time, with no frame_err.
